mc_sequencer: RTL and testbench

Multicycle control FSM for the RISC-V datapath. It sequences the shared ALU, memory port and architectural registers through the steps of each instruction. Each cycle it drives the load-enables of the datapath's enable-gated registers (IR/OldPC, PC, register file), the operand and result multiplexer selects, and the memory write strobe. It sits beside the datapath: it takes the opcode/funct3 fields from IR and the ALU flags, and returns control lines only.

---
 rtl/mc_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control FSM for the RISC-V datapath.
// Steps the shared ALU, memory port and architectural registers through each
// instruction and returns load-enables, mux selects and the memory write strobe.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (illegal instructions halt the
// sequencer and raise a sticky 'illegal' flag; otherwise they behave as NOPs).
module mc_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       retire,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_LUI
`ifdef MC_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    // Where DECODE goes for an undecodable instruction: trap or silent NOP.
`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    state_t state_q;
    state_t state_d;

    // Only beq/bne/blt/bge are supported; they all have funct3[1] clear.
    logic branch_ok;
    assign branch_ok = (funct3[1] == 1'b0);

    // State register; reset restarts the instruction stream at FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; write enables are gated off while in reset.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = branch_ok ? S_BRANCH : ILLEGAL_NEXT;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = ILLEGAL_NEXT;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                retire    = 1'b1;
                state_d   = S_FETCH;
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b001:  pc_write = ~zero;
                    3'b100:  pc_write = lt;
                    3'b101:  pc_write = ~lt;
                    default: pc_write = 1'b0;
                endcase
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JALR_PC;
            end
            S_JALR_PC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALU_WB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    // Immediate format follows the opcode held in IR, independent of state.
    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: drives directed and random instruction streams into
// mc_sequencer and compares every cycle against an instruction-level model.
// Honours MC_ILLEGAL_TRAP_EN the same way the design does.
module tb_mc_sequencer;

    localparam int C_LW   = 0;
    localparam int C_SW   = 1;
    localparam int C_R    = 2;
    localparam int C_I    = 3;
    localparam int C_BR   = 4;
    localparam int C_JAL  = 5;
    localparam int C_JALR = 6;
    localparam int C_LUI  = 7;
    localparam int C_ILL  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic       retire, illegal;
    logic [13:0] obs_ctrl;

    int errors = 0;
    int checks = 0;

    mc_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .pc_write(pc_write), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .retire(retire),
        .illegal(illegal)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    assign obs_ctrl = {pc_write, ir_write, mem_write, reg_write, adr_src,
                       alu_src_a, alu_src_b, alu_op, result_src, retire};

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] opcode_of(input int cls);
        case (cls)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_LUI:   return 7'b0110111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit is_known_opcode(input logic [6:0] op);
        for (int k = 0; k < 8; k++) begin
            if (opcode_of(k) == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Instruction length in cycles, FETCH included (illegal = FETCH + DECODE).
    function automatic int instr_len(input int cls);
        case (cls)
            C_LW, C_JALR: return 5;
            C_BR:         return 3;
            C_ILL:        return 2;
            default:      return 4;
        endcase
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] expected_imm(input logic [6:0] op);
        if (op == opcode_of(C_SW))  return 3'b001;
        if (op == opcode_of(C_BR))  return 3'b010;
        if (op == opcode_of(C_JAL)) return 3'b011;
        if (op == opcode_of(C_LUI)) return 3'b100;
        return 3'b000;
    endfunction

    // Per-instruction, per-cycle control word as described by the instruction steps.
    function automatic logic [13:0] expected_ctrl(input int cls, input int cyc, input bit taken);
        logic pw, iw, mw, rw, as, ret;
        logic [1:0] a, b, op, rs;
        int n;
        pw = 0; iw = 0; mw = 0; rw = 0; as = 0; ret = 0;
        a = 0; b = 0; op = 0; rs = 0;
        n = instr_len(cls);
        if (cyc == 1) begin
            pw = 1; iw = 1; b = 2'b10; rs = 2'b10;
        end else if (cyc == 2) begin
            a = 2'b01; b = 2'b01;
        end else if (cyc == n && cls != C_SW && cls != C_BR) begin
            rw = 1; ret = 1; rs = (cls == C_LW) ? 2'b01 : 2'b00;
        end else begin
            case (cls)
                C_LW, C_SW: begin
                    if (cyc == 3) begin a = 2'b10; b = 2'b01; end
                    else begin as = 1; mw = (cls == C_SW); ret = (cls == C_SW); end
                end
                C_R:    begin a = 2'b10; op = 2'b10; end
                C_I:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
                C_BR:   begin a = 2'b10; op = 2'b01; ret = 1; pw = taken; end
                C_JAL:  begin a = 2'b01; b = 2'b10; pw = 1; end
                C_JALR: begin
                    if (cyc == 3) begin a = 2'b10; b = 2'b01; end
                    else begin a = 2'b01; b = 2'b10; pw = 1; end
                end
                C_LUI:  begin a = 2'b11; b = 2'b01; end
                default: ;
            endcase
        end
        return {pw, iw, mw, rw, as, a, b, op, rs, ret};
    endfunction

    // One cycle of checks at the falling edge, then step to just after the next rising edge.
    task automatic check_cycle(input int cls, input int cyc, input bit rand_flags);
        bit taken;
        if (rand_flags) begin
            zero = 1'($urandom);
            lt   = 1'($urandom);
        end
        @(negedge clk);
        taken = branch_taken(funct3, zero, lt);
        checkOutput($sformatf("ctrl cls%0d cyc%0d op%b f3%b", cls, cyc, opcode, funct3),
                    32'(obs_ctrl), 32'(expected_ctrl(cls, cyc, taken)));
        checkOutput($sformatf("imm_src cls%0d cyc%0d", cls, cyc), 32'(imm_src),
                    32'(expected_imm(opcode)));
        checkOutput($sformatf("illegal cls%0d cyc%0d", cls, cyc), 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Runs one whole instruction; an illegal one is followed by the halt (and reset) when trapping.
    task automatic applyStimulus(input int cls, input logic [6:0] op, input logic [2:0] f3,
                                 input bit rand_flags);
        opcode = op;
        funct3 = f3;
        for (int c = 1; c <= instr_len(cls); c++) begin
            check_cycle(cls, c, rand_flags);
        end
`ifdef MC_ILLEGAL_TRAP_EN
        if (cls == C_ILL) begin
            for (int h = 0; h < 20; h++) begin
                zero = 1'($urandom);
                lt   = 1'($urandom);
                @(negedge clk);
                checkOutput($sformatf("halt ctrl h%0d", h), 32'(obs_ctrl), 32'd0);
                checkOutput($sformatf("halt illegal h%0d", h), 32'(illegal), 32'd1);
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
`endif
    endtask

    // Main sequence: reset, directed instructions, reset abort of a store, then random traffic.
    initial begin
        int cls;
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] br_f3 [4];
        logic [2:0] bad_f3 [4];
        br_f3  = '{3'b000, 3'b001, 3'b100, 3'b101};
        bad_f3 = '{3'b010, 3'b011, 3'b110, 3'b111};

        rst = 1'b1; opcode = 7'b0000011; funct3 = 3'b000; zero = 1'b0; lt = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            checkOutput($sformatf("reset pc_write r%0d", r), 32'(pc_write), 32'd0);
            checkOutput($sformatf("reset ir_write r%0d", r), 32'(ir_write), 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;

        applyStimulus(C_LW, opcode_of(C_LW), 3'b010, 1'b1);
        zero = 1'b1; applyStimulus(C_BR, opcode_of(C_BR), 3'b000, 1'b0);
        zero = 1'b0; applyStimulus(C_BR, opcode_of(C_BR), 3'b000, 1'b0);
        lt = 1'b0;   applyStimulus(C_BR, opcode_of(C_BR), 3'b101, 1'b0);
        applyStimulus(C_JAL, opcode_of(C_JAL), 3'b000, 1'b1);
        applyStimulus(C_JALR, opcode_of(C_JALR), 3'b000, 1'b1);
        applyStimulus(C_ILL, 7'b1111111, 3'b000, 1'b1);
        applyStimulus(C_R, opcode_of(C_R), 3'b000, 1'b1);

        // Store aborted by reset in its address step: no write enable may appear.
        opcode = opcode_of(C_SW);
        funct3 = 3'b010;
        check_cycle(C_SW, 1, 1'b1);
        check_cycle(C_SW, 2, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort sw write enables", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(C_SW, opcode_of(C_SW), 3'b010, 1'b1);

        for (int t = 0; t < 150; t++) begin
            cls = int'($urandom_range(0, 8));
            op  = opcode_of(cls);
            f3  = 3'($urandom_range(0, 7));
            if (cls == C_BR) begin
                f3 = br_f3[$urandom_range(0, 3)];
            end else if (cls == C_ILL) begin
                if ($urandom_range(0, 1) == 0) begin
                    op = opcode_of(C_BR);
                    f3 = bad_f3[$urandom_range(0, 3)];
                end else begin
                    do op = 7'($urandom_range(0, 127)); while (is_known_opcode(op));
                end
            end
            applyStimulus(cls, op, f3, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
